// File: rtl/wt_store_wbuf.sv
// Write-through store buffer: queues committed stores, merges bytes into the
// youngest unissued entry, issues in order and retires on in-order acks.
module wt_store_wbuf #(
  parameter int XLEN  = 32,
  parameter int PLEN  = 34,
  parameter int DEPTH = 2,
  parameter int TID_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              st_valid_i,
  output logic              st_ready_o,
  input  logic [PLEN-1:0]   st_paddr_i,
  input  logic [XLEN-1:0]   st_data_i,
  input  logic [XLEN/8-1:0] st_be_i,
  input  logic              st_nc_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [PLEN-1:0]   mem_paddr_o,
  output logic [XLEN-1:0]   mem_data_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [TID_W-1:0]  mem_tid_o,
  input  logic              mem_ack_i,
  input  logic [TID_W-1:0]  mem_ack_tid_i,
  input  logic [PLEN-1:0]   ld_paddr_i,
  output logic              ld_hit_o,
  output logic              empty_o
);
  localparam int NB  = XLEN / 8;
  localparam int OFF = $clog2(NB);
  localparam int AW  = PLEN - OFF;
  localparam int PW  = $clog2(DEPTH);

  typedef enum logic [1:0] {S_FREE, S_PEND, S_FLIGHT} slot_e;

  slot_e           r_state     [DEPTH];
  slot_e           w_state_nxt [DEPTH];
  logic [AW-1:0]   r_waddr     [DEPTH];
  logic [XLEN-1:0] r_data      [DEPTH];
  logic [NB-1:0]   r_be        [DEPTH];
  logic            r_nc        [DEPTH];

  logic [PW-1:0] r_alloc_ptr, r_issue_ptr, r_retire_ptr, w_young_ptr;
  logic [AW-1:0] w_st_waddr, w_ld_waddr;
  logic          w_merge, w_alloc_free, w_accept, w_alloc, w_grant;
  logic          w_unused;

  assign w_st_waddr  = st_paddr_i[PLEN-1:OFF];
  assign w_ld_waddr  = ld_paddr_i[PLEN-1:OFF];
  assign w_unused    = ^{st_paddr_i[OFF-1:0], ld_paddr_i[OFF-1:0]};
  assign w_young_ptr = r_alloc_ptr - PW'(1);

  // Merge never targets the issue slot, so a same-cycle grant cannot race it.
  assign w_merge = (r_state[w_young_ptr] == S_PEND) & ~r_nc[w_young_ptr] & ~st_nc_i &
                   (r_waddr[w_young_ptr] == w_st_waddr) & (w_young_ptr != r_issue_ptr);
  assign w_alloc_free = (r_state[r_alloc_ptr] == S_FREE);
  assign st_ready_o   = w_merge | w_alloc_free;
  assign w_accept     = st_valid_i & st_ready_o;
  assign w_alloc      = w_accept & ~w_merge;

  assign mem_req_o   = (r_state[r_issue_ptr] == S_PEND);
  assign w_grant     = mem_req_o & mem_gnt_i;
  assign mem_paddr_o = {r_waddr[r_issue_ptr], {OFF{1'b0}}};
  assign mem_data_o  = r_data[r_issue_ptr];
  assign mem_be_o    = r_be[r_issue_ptr];
  assign mem_tid_o   = TID_W'(r_issue_ptr);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) w_state_nxt[i] = r_state[i];
    if (w_alloc)   w_state_nxt[r_alloc_ptr]  = S_PEND;
    if (w_grant)   w_state_nxt[r_issue_ptr]  = S_FLIGHT;
    if (mem_ack_i) w_state_nxt[r_retire_ptr] = S_FREE;
  end

  always_comb begin
    ld_hit_o = 1'b0;
    empty_o  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_state[i] != S_FREE) begin
        empty_o = 1'b0;
        if (r_waddr[i] == w_ld_waddr) ld_hit_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_state[i] <= S_FREE;
      r_alloc_ptr  <= '0;
      r_issue_ptr  <= '0;
      r_retire_ptr <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_state[i] <= w_state_nxt[i];
      if (w_alloc)   r_alloc_ptr  <= r_alloc_ptr + PW'(1);
      if (w_grant)   r_issue_ptr  <= r_issue_ptr + PW'(1);
      if (mem_ack_i) r_retire_ptr <= r_retire_ptr + PW'(1);
    end
  end

  // Payload is qualified by slot state, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (w_alloc) begin
      r_waddr[r_alloc_ptr] <= w_st_waddr;
      r_data[r_alloc_ptr]  <= st_data_i;
      r_be[r_alloc_ptr]    <= st_be_i;
      r_nc[r_alloc_ptr]    <= st_nc_i;
    end else if (w_accept) begin
      r_be[w_young_ptr] <= r_be[w_young_ptr] | st_be_i;
      for (int b = 0; b < NB; b++)
        if (st_be_i[b]) r_data[w_young_ptr][8*b +: 8] <= st_data_i[8*b +: 8];
    end
  end

  a_ack_tid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_ack_i |-> (mem_ack_tid_i == TID_W'(r_retire_ptr)));
  a_ack_flight: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_ack_i |-> (r_state[r_retire_ptr] == S_FLIGHT));
endmodule
